console_arbiter: RTL and testbench

Round-robin arbiter that shares a single character-output channel, the console/print sink driven by the `hello_world`-style demo modules, between `NREQ` requesters. A requester holds the channel for a whole message, one DW-bit character per accepted beat, until it marks the final character or withdraws its request. The block sits between the message-producing modules and the single output sink, and is clocked by the same `clock` as the rest of the design.

---
 rtl/console_arbiter.sv | 174 +++++++++++++++++
 tb/tb_console_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/console_arbiter.sv
// console_arbiter: round-robin arbiter sharing one character-output sink
// between NREQ message producers. A requester keeps the channel for a whole
// message until it sends a character flagged with last, or drops its request.
// Optional feature macro: ARB_TIMEOUT_EN (adds a stall counter that forces a
// release after TIMEOUT back-pressured cycles and pulses timeout_err).
module console_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*DW-1:0]   data,
    output logic [NREQ-1:0]      grant,
    output logic                 out_valid,
    output logic [DW-1:0]        out_data,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DBW = $clog2(2 * NREQ);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // Elaboration-time parameter sanity checks
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("console_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("console_arbiter: TIMEOUT must be nonzero");
    end

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   ptr_q,   ptr_d;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0]   stall_q, stall_d;
    logic            terr_q,  terr_d;
`endif

    logic [2*NREQ-1:0] req_dbl;
    logic              sel_found;
    logic [PW-1:0]     sel_idx;
    logic [PW-1:0]     g_idx;
    logic [DW-1:0]     g_data;
    logic              req_g;
    logic              last_g;
    logic              xfer;
    logic [PW-1:0]     ptr_next;

    // Round-robin search for the first request at or after ptr, wrapping
    always_comb begin
        req_dbl   = {req, req};
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!sel_found && req_dbl[DBW'(int'(ptr_q) + int'(k))]) begin
                sel_found = 1'b1;
                if (int'(ptr_q) + int'(k) >= int'(NREQ)) begin
                    sel_idx = PW'(int'(ptr_q) + int'(k) - int'(NREQ));
                end else begin
                    sel_idx = PW'(int'(ptr_q) + int'(k));
                end
            end
        end
    end

    // Decode the granted index and mux its request, last flag and character
    always_comb begin
        g_idx  = '0;
        g_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                g_idx  = PW'(i);
                g_data = data[i*DW +: DW];
            end
        end
        req_g    = |(req & grant_q);
        last_g   = |(last & grant_q);
        ptr_next = (g_idx == PW'(NREQ - 1)) ? '0 : PW'(g_idx + PW'(1));
    end

    // Sink-side outputs; a cycle with reset asserted never completes a transfer
    always_comb begin
        busy      = (state_q == S_GRANT);
        grant     = grant_q;
        out_valid = busy & req_g & ~reset;
        out_data  = out_valid ? g_data : '0;
        xfer      = out_valid & out_ready;
`ifdef ARB_TIMEOUT_EN
        timeout_err = terr_q;
`else
        timeout_err = 1'b0;
`endif
    end

    // Next-state logic: grant selection in IDLE, release detection in GRANT
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        stall_d = stall_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (sel_found) begin
                    grant_d = NREQ'(1) << sel_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!req_g || (xfer && last_g)) begin
                    // Abort or final character: hand the channel on
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
`ifdef ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                else if (xfer) begin
                    stall_d = '0;
                end else if (stall_q == SW'(TIMEOUT - 1)) begin
                    // Sink stalled too long: force release like an abort
                    state_d = S_IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    stall_d = '0;
                    terr_d  = 1'b1;
                end else begin
                    stall_d = SW'(stall_q + SW'(1));
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            stall_q <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            stall_q <= stall_d;
            terr_q  <= terr_d;
`endif
        end
    end

endmodule

// File: tb/tb_console_arbiter.sv
// Directed bench for console_arbiter (NREQ=4, DW=8, TIMEOUT=16).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_console_arbiter;

    logic        clock;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [7:0]  d [4];
    logic [31:0] data;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        busy;
    logic        timeout_err;

    int total;
    int bad;

    assign data = {d[3], d[2], d[1], d[0]};

    console_arbiter #(.NREQ(4), .DW(8), .TIMEOUT(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .last        (last),
        .data        (data),
        .grant       (grant),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance to 1ns after the next rising edge
    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs follow freshly driven inputs
    task automatic settle;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v, input logic [7:0] dd);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".data"},  32'(out_data), 32'(dd));
        chk({tag, ".busy"},  32'(busy), 32'(g != 4'b0));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        req = '0; last = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) d[i] = '0;

        // Reset state
        tick; tick;
        chk_out("rst", 4'b0000, 1'b0, 8'h00);
        chk("rst.terr", 32'(timeout_err), 32'd0);
        reset = 1'b0;

        // Single message "Hi!" from requester 2
        req = 4'b0100; out_ready = 1'b1; d[2] = 8'h48;
        settle;
        chk_out("hi.idle", 4'b0000, 1'b0, 8'h00);
        tick;
        chk_out("hi.c0", 4'b0100, 1'b1, 8'h48);
        tick;
        d[2] = 8'h69; settle;
        chk_out("hi.c1", 4'b0100, 1'b1, 8'h69);
        tick;
        d[2] = 8'h21; last = 4'b0100; settle;
        chk_out("hi.c2", 4'b0100, 1'b1, 8'h21);
        tick;
        req = '0; last = '0; settle;
        chk_out("hi.rel", 4'b0000, 1'b0, 8'h00);
        chk("hi.ptr", 32'(dut.ptr_q), 32'd3);

        // Reset to bring ptr back to 0
        reset = 1'b1;
        tick; tick;
        chk("rst2.ptr", 32'(dut.ptr_q), 32'd0);
        reset = 1'b0;

        // Fairness: all request, one-character messages
        req = 4'b1111; last = 4'b1111;
        for (int i = 0; i < 4; i++) d[i] = 8'(8'hA0 + i);
        for (int k = 0; k < 5; k++) begin
            settle;
            chk_out($sformatf("rr%0d.idle", k), 4'b0000, 1'b0, 8'h00);
            tick;
            chk_out($sformatf("rr%0d.gnt", k), 4'(1 << (k % 4)), 1'b1, 8'(8'hA0 + (k % 4)));
            tick;
        end
        // ptr now 1; requesters 1 and 2 compete, 1 wins
        req = 4'b0110; last = '0; d[1] = 8'h11; d[2] = 8'h77;
        settle;
        chk_out("bp.idle", 4'b0000, 1'b0, 8'h00);
        tick;
        chk_out("bp.c0", 4'b0010, 1'b1, 8'h11);
        tick;
        d[1] = 8'h22; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle;
            chk_out($sformatf("bp.stall%0d", k), 4'b0010, 1'b1, 8'h22);
            tick;
        end
        out_ready = 1'b1; settle;
        chk_out("bp.c1", 4'b0010, 1'b1, 8'h22);
        tick;
        d[1] = 8'h33; settle;
        chk_out("bp.c2", 4'b0010, 1'b1, 8'h33);
        tick;
        // Abort by requester 1
        req = 4'b0100; settle;
        chk_out("ab.drop", 4'b0010, 1'b0, 8'h00);
        tick;
        chk_out("ab.rel", 4'b0000, 1'b0, 8'h00);
        tick;
        chk_out("ab.next", 4'b0100, 1'b1, 8'h77);
        req = 4'b0000;
        tick;
        chk_out("ab.end", 4'b0000, 1'b0, 8'h00);

        // Reset mid-message: ptr=3, requester 3 granted before 0
        req = 4'b1001; d[3] = 8'h51; d[0] = 8'h01;
        tick;
        chk_out("mr.c0", 4'b1000, 1'b1, 8'h51);
        tick;
        d[3] = 8'h52; settle;
        chk_out("mr.c1", 4'b1000, 1'b1, 8'h52);
        tick;
        d[3] = 8'h53; reset = 1'b1; settle;
        chk("mr.noxfer", 32'(out_valid), 32'd0);
        tick;
        chk_out("mr.rst", 4'b0000, 1'b0, 8'h00);
        reset = 1'b0;
        tick;
        chk_out("mr.restart", 4'b0001, 1'b1, 8'h01);
        req = 4'b0000;
        tick;
        chk_out("mr.end", 4'b0000, 1'b0, 8'h00);

        // Stalled sink: ptr=1, requester 1 granted
        req = 4'b0110; out_ready = 1'b0; d[1] = 8'h44; d[2] = 8'h55;
        tick;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("to.hold%0d", k), 32'(grant), 32'h2);
            chk($sformatf("to.terr%0d", k), 32'(timeout_err), 32'd0);
            tick;
        end
        chk("to.rel", 32'(grant), 32'h0);
        chk("to.pulse", 32'(timeout_err), 32'd1);
        tick;
        chk("to.next", 32'(grant), 32'h4);
        chk("to.pulse_end", 32'(timeout_err), 32'd0);
`else
        for (int k = 0; k < 100; k++) begin
            chk($sformatf("st.hold%0d", k), 32'(grant), 32'h2);
            chk($sformatf("st.terr%0d", k), 32'(timeout_err), 32'd0);
            tick;
        end
        chk_out("st.final", 4'b0010, 1'b1, 8'h44);
`endif
        req = '0;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
